// File: rtl/io_capture_if.sv
// io_capture_if
//   Event-drain bundle between io_capture (master) and its consumer (slave).
//   Ports:
//     out_evt_valid    FIFO head valid
//     in_evt_ready     consumer pops head when valid & ready
//     out_evt_pins     pin snapshot taken when the event was detected
//     out_evt_changed  mask of pins that produced the event
//     out_evt_ts       timestamp of the event
//     out_evt_ovf      one or more events were dropped before this one
//     out_fifo_level   number of entries held
interface io_capture_if #(
  parameter int IO_NUM_OF  = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 out_evt_valid;
  logic                 in_evt_ready;
  logic [IO_NUM_OF-1:0] out_evt_pins;
  logic [IO_NUM_OF-1:0] out_evt_changed;
  logic [TS_WIDTH-1:0]  out_evt_ts;
  logic                 out_evt_ovf;
  logic [LVL_W-1:0]     out_fifo_level;

  modport master (
    output out_evt_valid, out_evt_pins, out_evt_changed, out_evt_ts,
           out_evt_ovf, out_fifo_level,
    input  in_evt_ready
  );

  modport slave (
    input  out_evt_valid, out_evt_pins, out_evt_changed, out_evt_ts,
           out_evt_ovf, out_fifo_level,
    output in_evt_ready
  );
endinterface

// File: rtl/io_capture.sv
// io_capture
//   Read-back side of the shared io_pins pad bus. Synchronises the pads,
//   detects enabled rising/falling edges on pins configured as inputs and
//   queues each change as a timestamped event in a show-ahead FIFO.
//   Ports:
//     clk              system clock
//     rst              synchronous reset, active-high
//     in_io_pins       pad values (read side of io_pins)
//     in_io_direction  1 = pin driven by io_bitbang (never captured)
//     in_rise_en       per-pin rising-edge enable
//     in_fall_en       per-pin falling-edge enable
//     out_io_inval     synchronised pin values
//     evt              event-drain bundle (io_capture_if.master)
module io_capture #(
  parameter int IO_NUM_OF  = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IO_NUM_OF-1:0] in_io_pins,
  input  logic [IO_NUM_OF-1:0] in_io_direction,
  input  logic [IO_NUM_OF-1:0] in_rise_en,
  input  logic [IO_NUM_OF-1:0] in_fall_en,
  output logic [IO_NUM_OF-1:0] out_io_inval,
  io_capture_if.master         evt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [1:0] ARM_DONE = 2'd3;

  logic [IO_NUM_OF-1:0] sync1;
  logic [IO_NUM_OF-1:0] sync2;
  logic [IO_NUM_OF-1:0] prev;
  logic [1:0]           arm;
  logic [TS_WIDTH-1:0]  ts_cnt;

  logic [IO_NUM_OF-1:0] rise;
  logic [IO_NUM_OF-1:0] fall;
  logic [IO_NUM_OF-1:0] changed;

  logic [IO_NUM_OF-1:0] mem_pins    [FIFO_DEPTH];
  logic [IO_NUM_OF-1:0] mem_changed [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]  mem_ts      [FIFO_DEPTH];
  logic                 mem_ovf     [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             drop_flag;

  logic evt_valid;
  logic full;
  logic push_req;
  logic push_ok;
  logic pop;
  logic drop;

  // Synchroniser, edge history, arm counter and timestamp. The sync and
  // prev registers keep running while disarmed so that, once armed, prev
  // already reflects the settled pad state and no phantom edge appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      arm    <= '0;
      ts_cnt <= '0;
    end else begin
      sync1  <= in_io_pins;
      sync2  <= sync1;
      prev   <= sync2;
      ts_cnt <= ts_cnt + 1'b1;
      if (arm != ARM_DONE) begin
        arm <= arm + 2'd1;
      end
    end
  end

  assign rise    = sync2 & ~prev & in_rise_en & ~in_io_direction;
  assign fall    = ~sync2 & prev & in_fall_en & ~in_io_direction;
  assign changed = (arm == ARM_DONE) ? (rise | fall) : '0;

  assign evt_valid = (level != '0);
  assign full      = (level == LVL_FULL);
  assign push_req  = |changed;
  assign pop       = evt_valid & evt.in_evt_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      drop_flag <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // The flag is consumed by the accepted push that carries it.
      if (drop) begin
        drop_flag <= 1'b1;
      end else if (push_ok) begin
        drop_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_pins[wr_ptr]    <= sync2;
      mem_changed[wr_ptr] <= changed;
      mem_ts[wr_ptr]      <= ts_cnt;
      mem_ovf[wr_ptr]     <= drop_flag;
    end
  end

  // Head fields are forced to zero when empty so that stale or
  // uninitialised storage never reaches the consumer.
  assign out_io_inval        = sync2;
  assign evt.out_evt_valid   = evt_valid;
  assign evt.out_evt_pins    = evt_valid ? mem_pins[rd_ptr]    : '0;
  assign evt.out_evt_changed = evt_valid ? mem_changed[rd_ptr] : '0;
  assign evt.out_evt_ts      = evt_valid ? mem_ts[rd_ptr]      : '0;
  assign evt.out_evt_ovf     = evt_valid ? mem_ovf[rd_ptr]     : 1'b0;
  assign evt.out_fifo_level  = level;

endmodule

// File: tb/tb_io_capture.sv
module tb_io_capture;

  typedef struct packed {
    logic [9:0]  pins;
    logic [9:0]  changed;
    logic [15:0] ts;
    logic        ovf;
  } evt_t;

  logic       clk;
  logic       rst;
  logic [9:0] pins;
  logic [9:0] dir;
  logic [9:0] rise_en;
  logic [9:0] fall_en;
  logic [9:0] inval;
  logic [15:0] tb_ts;

  int checks;
  int failures;
  evt_t exp_q[$];

  io_capture_if #(.IO_NUM_OF(10), .FIFO_DEPTH(8), .TS_WIDTH(16)) evt_if ();

  io_capture #(.IO_NUM_OF(10), .FIFO_DEPTH(8), .TS_WIDTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_io_pins      (pins),
    .in_io_direction (dir),
    .in_rise_en      (rise_en),
    .in_fall_en      (fall_en),
    .out_io_inval    (inval),
    .evt             (evt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference time: number of clock edges since the last reset edge.
  always @(posedge clk) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 16'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Drive a new pad value just before the next rising edge; if an event is
  // expected, its timestamp is the counter value two edges later.
  task automatic drive(input logic [9:0] new_pins, input logic [9:0] exp_chg,
                       input logic exp_push, input logic exp_ovf);
    evt_t e;
    @(negedge clk);
    pins = new_pins;
    if (exp_push) begin
      e.pins    = new_pins;
      e.changed = exp_chg;
      e.ts      = tb_ts + 16'd2;
      e.ovf     = exp_ovf;
      exp_q.push_back(e);
    end
  endtask

  task automatic toggle(input int b, input logic exp_push, input logic exp_ovf);
    logic [9:0] m;
    m = 10'd1 << b;
    drive(pins ^ m, m, exp_push, exp_ovf);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares every popped head against the queue.
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && evt_if.out_evt_valid && evt_if.in_evt_ready) begin
        if (exp_q.size() == 0) begin
          check("evt_unexpected", {22'd0, evt_if.out_evt_changed}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("evt_pins",    {22'd0, evt_if.out_evt_pins},    {22'd0, e.pins});
          check("evt_changed", {22'd0, evt_if.out_evt_changed}, {22'd0, e.changed});
          check("evt_ts",      {16'd0, evt_if.out_evt_ts},      {16'd0, e.ts});
          check("evt_ovf",     {31'd0, evt_if.out_evt_ovf},     {31'd0, e.ovf});
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    pins     = 10'h3FF;
    dir      = 10'h000;
    rise_en  = 10'h3FF;
    fall_en  = 10'h3FF;
    evt_if.in_evt_ready = 1'b1;

    // 1: pins high through reset must not create events
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", {31'd0, evt_if.out_evt_valid}, 32'd0);
    check("rst_level", {28'd0, evt_if.out_fifo_level}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_inval", {22'd0, inval}, 32'd0);
    check("post_rst_valid", {31'd0, evt_if.out_evt_valid}, 32'd0);
    settle(1);
    check("sync_lat1_inval", {22'd0, inval}, 32'd0);
    settle(1);
    check("sync_lat2_inval", {22'd0, inval}, 32'h3FF);
    for (int i = 0; i < 10; i++) begin
      settle(1);
      check("arm_no_evt", {31'd0, evt_if.out_evt_valid}, 32'd0);
    end
    drive(10'h000, 10'h3FF, 1'b1, 1'b0);
    settle(6);
    check("t1_drained", exp_q.size(), 32'd0);

    // 2: multi-pin rise, exact latency
    evt_if.in_evt_ready = 1'b0;
    drive(10'h2AA, 10'h2AA, 1'b1, 1'b0);
    settle(1);
    check("lat_e0_valid", {31'd0, evt_if.out_evt_valid}, 32'd0);
    settle(1);
    check("lat_e1_valid", {31'd0, evt_if.out_evt_valid}, 32'd0);
    settle(1);
    check("lat_e2_valid", {31'd0, evt_if.out_evt_valid}, 32'd1);
    check("lat_e2_level", {28'd0, evt_if.out_fifo_level}, 32'd1);
    drive(10'h000, 10'h2AA, 1'b1, 1'b0);
    settle(4);
    check("t2_level2", {28'd0, evt_if.out_fifo_level}, 32'd2);
    evt_if.in_evt_ready = 1'b1;
    settle(4);
    check("t2_level0", {28'd0, evt_if.out_fifo_level}, 32'd0);
    evt_if.in_evt_ready = 1'b0;

    // 3: direction masking and fall enable
    dir = 10'h255;
    drive(10'h3FF, 10'h1AA, 1'b1, 1'b0);
    settle(4);
    check("dir_level", {28'd0, evt_if.out_fifo_level}, 32'd1);
    fall_en = 10'h000;
    drive(10'h000, 10'h000, 1'b0, 1'b0);
    settle(5);
    check("fall_dis_level", {28'd0, evt_if.out_fifo_level}, 32'd1);
    check("fall_dis_inval", {22'd0, inval}, 32'd0);
    dir = 10'h000;
    fall_en = 10'h3FF;
    evt_if.in_evt_ready = 1'b1;
    settle(3);
    check("t3_drained", exp_q.size(), 32'd0);
    evt_if.in_evt_ready = 1'b0;

    // 4: overflow, sticky drop flag carried by next accepted event
    for (int i = 0; i < 10; i++) toggle(i, (i < 8), 1'b0);
    settle(4);
    check("full_level", {28'd0, evt_if.out_fifo_level}, 32'd8);
    @(negedge clk); evt_if.in_evt_ready = 1'b1;
    @(negedge clk); evt_if.in_evt_ready = 1'b0;
    toggle(0, 1'b1, 1'b1);
    settle(4);
    check("ovf_push_level", {28'd0, evt_if.out_fifo_level}, 32'd8);
    @(negedge clk); evt_if.in_evt_ready = 1'b1;
    @(negedge clk); evt_if.in_evt_ready = 1'b0;
    toggle(1, 1'b1, 1'b0);
    settle(4);
    check("ovf_clr_level", {28'd0, evt_if.out_fifo_level}, 32'd8);
    evt_if.in_evt_ready = 1'b1;
    settle(12);
    check("t4_level0", {28'd0, evt_if.out_fifo_level}, 32'd0);
    check("t4_drained", exp_q.size(), 32'd0);
    evt_if.in_evt_ready = 1'b0;

    // 5: push while full with a simultaneous pop is accepted
    for (int i = 0; i < 8; i++) toggle(i, 1'b1, 1'b0);
    settle(4);
    check("refill_level", {28'd0, evt_if.out_fifo_level}, 32'd8);
    toggle(8, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk); evt_if.in_evt_ready = 1'b1;
    @(negedge clk); evt_if.in_evt_ready = 1'b0;
    #1;
    check("pushpop_level", {28'd0, evt_if.out_fifo_level}, 32'd8);
    evt_if.in_evt_ready = 1'b1;
    settle(12);
    check("t5_drained", exp_q.size(), 32'd0);

    // 6: timestamp wrap, then reset with events pending
    begin
      int n;
      n = 0;
      while (tb_ts != 16'hFFFB && n < 70000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 70000) begin
        checks++;
        failures++;
        $display("FAIL wrap_wait actual=timeout required=ts_0xFFFB");
      end
    end
    for (int i = 0; i < 4; i++) toggle(i, 1'b1, 1'b0);
    settle(6);
    check("wrap_drained", exp_q.size(), 32'd0);
    evt_if.in_evt_ready = 1'b0;
    for (int i = 4; i < 7; i++) toggle(i, 1'b1, 1'b0);
    settle(4);
    check("pre_rst_level", {28'd0, evt_if.out_fifo_level}, 32'd3);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    settle(1);
    check("mid_rst_valid", {31'd0, evt_if.out_evt_valid}, 32'd0);
    check("mid_rst_level", {28'd0, evt_if.out_fifo_level}, 32'd0);
    rst = 1'b0;
    evt_if.in_evt_ready = 1'b1;
    settle(10);
    check("post_mid_rst_valid", {31'd0, evt_if.out_evt_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
